// File: rtl/mem_param_pkg.sv
// Shared layout of the 256-bit modulation-parameter memory word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by the memory writer, this read stage and the signal-generator core.
package mem_param_pkg;

  localparam int PARAM_W = 232;
  localparam int MEM_W   = 256;

  // Frequency-modulation coefficients and gain: 18 bits each.
  localparam int FMOD_W      = 18;
  localparam int FMOD_C0_LSB = 0;
  localparam int FMOD_C1_LSB = 18;
  localparam int FMOD_C2_LSB = 36;
  localparam int FMOD_C3_LSB = 54;
  localparam int FMOD_C4_LSB = 72;
  localparam int FMOD_C5_LSB = 90;
  localparam int FMOD_G_LSB  = 108;

  // Amplitude-modulation coefficients and gain: 16 bits each.
  localparam int AMOD_W      = 16;
  localparam int AMOD_C0_LSB = 126;
  localparam int AMOD_C1_LSB = 142;
  localparam int AMOD_C2_LSB = 158;
  localparam int AMOD_C3_LSB = 174;
  localparam int AMOD_G_LSB  = 190;

  localparam int POFF_W      = 18;
  localparam int POFF_LSB    = 206;
  localparam int CTRL_W      = 8;
  localparam int CTRL_LSB    = 224;

  typedef logic [PARAM_W-1:0] param_word_t;
  typedef logic [MEM_W-1:0]   mem_word_t;

  // Field view of a parameter word, MSB first; bit positions match the LSB constants.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [POFF_W-1:0] poff;
    logic [AMOD_W-1:0] amod_g;
    logic [AMOD_W-1:0] amod_c3;
    logic [AMOD_W-1:0] amod_c2;
    logic [AMOD_W-1:0] amod_c1;
    logic [AMOD_W-1:0] amod_c0;
    logic [FMOD_W-1:0] fmod_g;
    logic [FMOD_W-1:0] fmod_c5;
    logic [FMOD_W-1:0] fmod_c4;
    logic [FMOD_W-1:0] fmod_c3;
    logic [FMOD_W-1:0] fmod_c2;
    logic [FMOD_W-1:0] fmod_c1;
    logic [FMOD_W-1:0] fmod_c0;
  } param_fields_t;

endpackage

// File: rtl/param_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output word.
// Latency: a push into an empty FIFO is visible on the next cycle.
// Backpressure: pop only when valid; push while full (without pop) is an error.
// Ports: clk, rstn (sync, active-low); push_i/din_i write side; pop_i read side;
//        dout_o/vld_o head word; count_o/full_o/empty_o occupancy status.
module param_fifo #(
  parameter int W     = 232,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     vld_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign vld_o   = ~empty_o;
  assign count_o = count_q;
  assign dout_o  = dout_q;

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot in the same cycle, so push at full is fine with a pop.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // Next head comes from the incoming word when it lands exactly at the new
    // read pointer (empty FIFO, or single entry being popped), else from storage.
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      dout_d = din_i;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rstn)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/mem_param_reader.sv
// Reads parameter words from a fixed-latency memory on command and streams them out.
// Latency: accept in cycle 0 -> mem_addr in cycle 1 -> m_axis_tvalid in cycle 2+MEM_LAT.
// Backpressure: credit based; commands are refused once FIFO words plus in-flight reads fill the FIFO.
// Ports: clk, rstn (sync, active-low); s_axis_* read commands (address in tdata[N-1:0]);
//        mem_addr/mem_dout memory read port; m_axis_* parameter words; rd_cnt words delivered.
module mem_param_reader
  import mem_param_pkg::*;
#(
  parameter int N          = 16,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               rstn,
  input  logic               clk,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [31:0]        s_axis_tdata,
  output logic [15:0]        mem_addr,
  input  logic [MEM_W-1:0]   mem_dout,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [PARAM_W-1:0] m_axis_tdata,
  output logic [31:0]        rd_cnt
);

  localparam int OW = 8;

  logic [MEM_LAT:0]              pipe_q, pipe_d;
  logic [15:0]                   mem_addr_q, mem_addr_d;
  logic [31:0]                   rd_cnt_q, rd_cnt_d;
  logic                          accept, pop, push;
  logic                          fifo_vld, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [OW-1:0]                 occupancy;
  param_word_t                   fifo_dout;
  logic                          unused_bits;

  // Every accepted command owns a FIFO slot from accept until its word is popped.
  assign occupancy = OW'(fifo_count) + OW'($countones(pipe_q));

  assign m_axis_tvalid = rstn & fifo_vld;
  assign m_axis_tdata  = fifo_dout;
  assign pop           = m_axis_tvalid & m_axis_tready;

  // A pop in this cycle hands its slot straight to a new command, which keeps
  // one-per-cycle streaming with FIFO_DEPTH = MEM_LAT+2. No path from s_axis_tvalid.
  assign s_axis_tready = rstn & ((occupancy < OW'(FIFO_DEPTH)) | pop);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Last pipe stage lines up with the cycle mem_dout carries the addressed word.
  assign push = pipe_q[MEM_LAT];

  assign mem_addr = mem_addr_q;
  assign rd_cnt   = rd_cnt_q;

  always_comb begin
    pipe_d     = {pipe_q[MEM_LAT-1:0], accept};
    mem_addr_d = accept ? 16'(s_axis_tdata[N-1:0]) : mem_addr_q;
    rd_cnt_d   = rd_cnt_q + {31'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_q     <= '0;
      mem_addr_q <= '0;
      rd_cnt_q   <= '0;
    end else begin
      pipe_q     <= pipe_d;
      mem_addr_q <= mem_addr_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  param_fifo #(
    .W     (PARAM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .din_i   (mem_dout[PARAM_W-1:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .vld_o   (fifo_vld),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Upper command bits and the top of the memory word carry nothing for this stage.
  assign unused_bits = ^{s_axis_tdata[31:N], mem_dout[MEM_W-1:PARAM_W], fifo_full, fifo_empty};

endmodule
